// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_pkg
// Description : Shared types and constants for the JPEG block sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package jpeg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_DCT    = 4'd2,
    ST_CAPT   = 4'd3,
    ST_QWAIT  = 4'd4,
    ST_QWRITE = 4'd5,
    ST_HSTART = 4'd6,
    ST_HWAIT  = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

  localparam int BLOCK_PIX  = 64;
  localparam int BLOCK_ROWS = 8;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

  // Component order within one 4:4:4 MCU.
  function automatic logic [1:0] next_comp(input logic [1:0] comp);
    case (comp)
      COMP_Y:  return COMP_CB;
      COMP_CB: return COMP_CR;
      default: return COMP_Y;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_block_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_block_sequencer_if
// Description : Control/handshake bundle between the sequencer and datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface jpeg_block_sequencer_if #(
  parameter int MCU_W = 16
);
  logic             start;
  logic             abort;
  logic [MCU_W-1:0] frame_mcus;
  logic             pix_valid;
  logic             pix_ready;
  logic             input_1pix_enable;
  logic             dct_enable;
  logic             dct_input_enable;
  logic [7:0]       matrix_row;
  logic             zigzag_input_enable;
  logic             is_luminance;
  logic             huff_start;
  logic             huff_done;
  logic             block_done;
  logic             frame_done;
  logic             busy;
  logic [MCU_W-1:0] mcu_count;

  modport master (
    input  start, abort, frame_mcus, pix_valid, huff_done,
    output pix_ready, input_1pix_enable, dct_enable, dct_input_enable,
           matrix_row, zigzag_input_enable, is_luminance, huff_start,
           block_done, frame_done, busy, mcu_count
  );

  modport slave (
    output start, abort, frame_mcus, pix_valid, huff_done,
    input  pix_ready, input_1pix_enable, dct_enable, dct_input_enable,
           matrix_row, zigzag_input_enable, is_luminance, huff_start,
           block_done, frame_done, busy, mcu_count
  );
endinterface
`default_nettype wire

// File: rtl/jpeg_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_wait_counter
// Description : Loadable down-counter; o_done is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_wait_counter #(
  parameter int WIDTH = 3
) (
  input  wire             clk,
  input  wire             rst,
  input  wire             i_clr,
  input  wire             i_load,
  input  wire [WIDTH-1:0] i_load_val,
  output logic            o_done
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/jpeg_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_block_sequencer
// Description : Steps each 8x8 block through load, DCT, quantize and Huffman.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_block_sequencer
  import jpeg_pkg::*;
#(
  parameter int DCT_LAT   = 4,
  parameter int QUANT_LAT = 2,
  parameter int MCU_W     = 16
) (
  input wire                      clock,
  input wire                      reset,
  jpeg_block_sequencer_if.master  bus
);

  localparam int c_wait_max = (DCT_LAT > QUANT_LAT) ? DCT_LAT : QUANT_LAT;
  localparam int c_wait_w   = (c_wait_max > 1) ? $clog2(c_wait_max) : 1;
  localparam logic [c_wait_w-1:0] c_dct_load   = c_wait_w'(DCT_LAT - 1);
  localparam logic [c_wait_w-1:0] c_quant_load = c_wait_w'(QUANT_LAT - 1);
  localparam logic [5:0] c_last_pix = 6'(BLOCK_PIX - 1);
  localparam logic [2:0] c_last_row = 3'(BLOCK_ROWS - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [5:0]          r_pix_cnt;
  logic [2:0]          r_row;
  logic [1:0]          r_comp;
  logic                r_is_lum;
  logic [MCU_W-1:0]    r_frame_mcus;
  logic [MCU_W-1:0]    r_mcu_count;
  logic                r_zero_frame;
  logic                w_pix_ready;
  logic                w_accept;
  logic                w_start_ok;
  logic                w_last_block;
  logic [MCU_W-1:0]    w_mcu_inc;
  logic                w_wait_load;
  logic [c_wait_w-1:0] w_wait_val;
  logic                w_wait_done;

  assign w_pix_ready  = (r_state == ST_LOAD);
  assign w_accept     = bus.pix_valid & w_pix_ready;
  assign w_start_ok   = (r_state == ST_IDLE) && bus.start && (bus.frame_mcus != '0);
  assign w_mcu_inc    = r_mcu_count + MCU_W'(1);
  assign w_last_block = (r_comp == COMP_CR) && (w_mcu_inc == r_frame_mcus);

  jpeg_wait_counter #(
    .WIDTH (c_wait_w)
  ) u_wait (
    .clk        (clock),
    .rst        (reset),
    .i_clr      (bus.abort),
    .i_load     (w_wait_load),
    .i_load_val (w_wait_val),
    .o_done     (w_wait_done)
  );

  // The wait counter is loaded on the edge that enters DCT/QWAIT, so it
  // reads LAT-1 in the first cycle and done in the LAT-th cycle.
  always_comb begin
    w_state_next = r_state;
    w_wait_load  = 1'b0;
    w_wait_val   = c_dct_load;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_state_next = ST_LOAD;
      ST_LOAD: begin
        if (w_accept && (r_pix_cnt == c_last_pix)) begin
          w_state_next = ST_DCT;
          w_wait_load  = 1'b1;
          w_wait_val   = c_dct_load;
        end
      end
      ST_DCT:    if (w_wait_done) w_state_next = ST_CAPT;
      ST_CAPT: begin
        w_state_next = ST_QWAIT;
        w_wait_load  = 1'b1;
        w_wait_val   = c_quant_load;
      end
      ST_QWAIT:  if (w_wait_done) w_state_next = ST_QWRITE;
      ST_QWRITE: begin
        if (r_row == c_last_row) begin
          w_state_next = ST_HSTART;
        end else begin
          w_state_next = ST_QWAIT;
          w_wait_load  = 1'b1;
          w_wait_val   = c_quant_load;
        end
      end
      ST_HSTART: w_state_next = ST_HWAIT;
      ST_HWAIT:  if (bus.huff_done) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = w_last_block ? ST_IDLE : ST_LOAD;
      default:   w_state_next = ST_IDLE;
    endcase
    if (bus.abort) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pix_cnt    <= '0;
      r_row        <= '0;
      r_comp       <= COMP_Y;
      r_is_lum     <= 1'b1;
      r_frame_mcus <= '0;
      r_mcu_count  <= '0;
      r_zero_frame <= 1'b0;
    end else if (bus.abort) begin
      r_state      <= ST_IDLE;
      r_pix_cnt    <= '0;
      r_row        <= '0;
      r_comp       <= COMP_Y;
      r_is_lum     <= 1'b1;
      r_mcu_count  <= '0;
      r_zero_frame <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_zero_frame <= (r_state == ST_IDLE) && bus.start && (bus.frame_mcus == '0);
      if (w_accept) r_pix_cnt <= r_pix_cnt + 6'd1;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_frame_mcus <= bus.frame_mcus;
            r_comp       <= COMP_Y;
            r_is_lum     <= 1'b1;
            r_mcu_count  <= '0;
          end
        end
        ST_CAPT:   r_row <= '0;
        ST_QWRITE: if (r_row != c_last_row) r_row <= r_row + 3'd1;
        ST_DONE: begin
          r_comp   <= next_comp(r_comp);
          r_is_lum <= (next_comp(r_comp) == COMP_Y);
          if (r_comp == COMP_CR) r_mcu_count <= w_mcu_inc;
        end
        default: ;
      endcase
    end
  end

  assign bus.pix_ready           = w_pix_ready;
  assign bus.input_1pix_enable   = w_accept;
  assign bus.dct_enable          = (r_state == ST_DCT);
  assign bus.dct_input_enable    = (r_state == ST_CAPT);
  assign bus.matrix_row          = {5'd0, r_row};
  assign bus.zigzag_input_enable = (r_state == ST_QWRITE);
  assign bus.is_luminance        = r_is_lum;
  assign bus.huff_start          = (r_state == ST_HSTART);
  assign bus.block_done          = (r_state == ST_DONE);
  assign bus.frame_done          = ((r_state == ST_DONE) && w_last_block) | r_zero_frame;
  assign bus.busy                = (r_state != ST_IDLE);
  assign bus.mcu_count           = r_mcu_count;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jpeg_block_sequencer
// Description : Directed self-checking bench for jpeg_block_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_block_sequencer;

  logic clock;
  logic reset;

  jpeg_block_sequencer_if #(.MCU_W(16)) bus ();

  jpeg_block_sequencer #(
    .DCT_LAT   (4),
    .QUANT_LAT (2),
    .MCU_W     (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Event monitor, sampled on the falling edge.
  int cyc_n = 0;
  int m_accept = 0, m_dct = 0, m_capt = 0, m_zz = 0, m_block = 0, m_frame = 0;
  int m_frame_blk = 0, m_gap_bad = 0, m_row_bad = 0, m_acc_bad = 0, m_late = 0, m_ready = 0;
  int m_blk_len = 0, m_span = 0, m_hs_to_bd = 0, m_dct_run = 0;
  logic [7:0] m_lum = '0;
  int blk_open = 0, blk_start = 0, acc_in_blk = 0, last_acc = 0, dct_run = 0;
  int zz_in_blk = 0, gap = 0, hs_cyc = 0;

  always @(negedge clock) begin
    cyc_n++;
    if (reset || !bus.busy) begin
      blk_open = 0; acc_in_blk = 0; zz_in_blk = 0; dct_run = 0;
    end
    if (bus.input_1pix_enable) begin
      m_accept++;
      if (blk_open == 0) begin blk_open = 1; blk_start = cyc_n; end
      acc_in_blk++;
      last_acc = cyc_n;
      if (acc_in_blk == 64) m_span = cyc_n - blk_start + 1;
    end
    if (bus.dct_enable) begin
      m_dct++;
      if (dct_run == 0) begin
        if (acc_in_blk != 64) m_acc_bad++;
        if (cyc_n != last_acc + 1) m_late++;
      end
      dct_run++;
    end
    if (bus.dct_input_enable) begin
      m_capt++; m_dct_run = dct_run; dct_run = 0; zz_in_blk = 0; gap = 0;
    end else if (bus.zigzag_input_enable) begin
      m_zz++;
      if (gap != 2) m_gap_bad++;
      if (bus.matrix_row != zz_in_blk[7:0]) m_row_bad++;
      zz_in_blk++; gap = 0;
    end else begin
      gap++;
    end
    if (bus.huff_start) hs_cyc = cyc_n;
    if (bus.block_done) begin
      m_block++;
      m_lum = {m_lum[6:0], bus.is_luminance};
      m_blk_len = cyc_n - blk_start + 1;
      m_hs_to_bd = cyc_n - hs_cyc;
      blk_open = 0; acc_in_blk = 0;
      if (bus.frame_done) m_frame_blk++;
    end
    if (bus.frame_done) m_frame++;
    if (bus.pix_ready) m_ready++;
  end

  int b_accept, b_dct, b_capt, b_zz, b_block, b_frame, b_frame_blk;
  int b_gap, b_row, b_acc, b_late, b_ready;

  task automatic snap();
    b_accept = m_accept; b_dct = m_dct; b_capt = m_capt; b_zz = m_zz;
    b_block = m_block; b_frame = m_frame; b_frame_blk = m_frame_blk;
    b_gap = m_gap_bad; b_row = m_row_bad; b_acc = m_acc_bad; b_late = m_late;
    b_ready = m_ready;
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  // Runs one frame; answers huff_start with huff_done hdelay cycles later
  // (0 = already high during HSTART). poke drives start during HWAIT.
  task automatic drive_frame(input int mcus, input bit stall, input int hdelay,
                             input bit poke, output bit got);
    int hcount, ph, n;
    hcount = -1; ph = 0; n = 0; got = 1'b0;
    bus.frame_mcus = 16'(mcus);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    while (!got && n < 1500) begin
      if (bus.block_done) hcount = -1;
      else if (bus.huff_start) hcount = 0;
      else if (hcount >= 0) hcount++;
      bus.huff_done = (hcount >= 0) && (hcount >= hdelay);
      if (stall) begin
        bus.pix_valid = bus.pix_ready && (ph % 2 == 0);
        ph = bus.pix_ready ? ph + 1 : 0;
      end else begin
        bus.pix_valid = 1'b1;
      end
      bus.start = poke && (hcount > 0);
      if (poke && hcount > 0) bus.frame_mcus = 16'd5;
      #1;
      got = bus.frame_done;
      cyc();
      n++;
    end
    bus.start = 1'b0; bus.pix_valid = 1'b0; bus.huff_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %0b expected 0", bus.busy); else n_pass++;
    n_chk++; if (bus.pix_ready !== 1'b0) $display("FAIL rst_pix_ready: got %0b expected 0", bus.pix_ready); else n_pass++;
    n_chk++; if ({bus.dct_enable, bus.dct_input_enable, bus.zigzag_input_enable} !== 3'b000)
      $display("FAIL rst_enables: got %03b expected 000", {bus.dct_enable, bus.dct_input_enable, bus.zigzag_input_enable}); else n_pass++;
    n_chk++; if ({bus.huff_start, bus.block_done, bus.frame_done} !== 3'b000)
      $display("FAIL rst_pulses: got %03b expected 000", {bus.huff_start, bus.block_done, bus.frame_done}); else n_pass++;
    n_chk++; if (bus.matrix_row !== 8'd0) $display("FAIL rst_matrix_row: got %0d expected 0", bus.matrix_row); else n_pass++;
    n_chk++; if (bus.is_luminance !== 1'b1) $display("FAIL rst_is_lum: got %0b expected 1", bus.is_luminance); else n_pass++;
    n_chk++; if (bus.mcu_count !== 16'd0) $display("FAIL rst_mcu_count: got %0d expected 0", bus.mcu_count); else n_pass++;
    cyc();
  endtask

  task automatic test_single_frame();
    bit got;
    snap();
    drive_frame(1, 1'b0, 3, 1'b0, got);
    #1;
    n_chk++; if (got !== 1'b1) $display("FAIL t1_timeout: got %0b expected 1", got); else n_pass++;
    n_chk++; if (m_accept - b_accept !== 192) $display("FAIL t1_accepts: got %0d expected 192", m_accept - b_accept); else n_pass++;
    n_chk++; if (m_dct - b_dct !== 12) $display("FAIL t1_dct_cycles: got %0d expected 12", m_dct - b_dct); else n_pass++;
    n_chk++; if (m_dct_run !== 4) $display("FAIL t1_dct_run: got %0d expected 4", m_dct_run); else n_pass++;
    n_chk++; if (m_capt - b_capt !== 3) $display("FAIL t1_capt: got %0d expected 3", m_capt - b_capt); else n_pass++;
    n_chk++; if (m_zz - b_zz !== 24) $display("FAIL t1_zz: got %0d expected 24", m_zz - b_zz); else n_pass++;
    n_chk++; if (m_row_bad - b_row !== 0) $display("FAIL t1_zz_row: got %0d expected 0", m_row_bad - b_row); else n_pass++;
    n_chk++; if (m_gap_bad - b_gap !== 0) $display("FAIL t1_zz_gap: got %0d expected 0", m_gap_bad - b_gap); else n_pass++;
    n_chk++; if (m_block - b_block !== 3) $display("FAIL t1_blocks: got %0d expected 3", m_block - b_block); else n_pass++;
    n_chk++; if (m_lum[2:0] !== 3'b100) $display("FAIL t1_lum_order: got %03b expected 100", m_lum[2:0]); else n_pass++;
    n_chk++; if (m_frame_blk - b_frame_blk !== 1) $display("FAIL t1_frame_with_block: got %0d expected 1", m_frame_blk - b_frame_blk); else n_pass++;
    n_chk++; if (m_frame - b_frame !== 1) $display("FAIL t1_frames: got %0d expected 1", m_frame - b_frame); else n_pass++;
    n_chk++; if (m_blk_len !== 98) $display("FAIL t1_block_latency: got %0d expected 98", m_blk_len); else n_pass++;
    n_chk++; if (m_hs_to_bd !== 4) $display("FAIL t1_huff_to_done: got %0d expected 4", m_hs_to_bd); else n_pass++;
    n_chk++; if (bus.mcu_count !== 16'd1) $display("FAIL t1_mcu_count: got %0d expected 1", bus.mcu_count); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL t1_idle_after: got %0b expected 0", bus.busy); else n_pass++;
    cyc();
  endtask

  task automatic test_pixel_stall();
    bit got;
    snap();
    drive_frame(1, 1'b1, 3, 1'b0, got);
    #1;
    n_chk++; if (got !== 1'b1) $display("FAIL t2_timeout: got %0b expected 1", got); else n_pass++;
    n_chk++; if (m_accept - b_accept !== 192) $display("FAIL t2_accepts: got %0d expected 192", m_accept - b_accept); else n_pass++;
    n_chk++; if (m_span !== 127) $display("FAIL t2_accept_span: got %0d expected 127", m_span); else n_pass++;
    n_chk++; if (m_acc_bad - b_acc !== 0) $display("FAIL t2_dct_early: got %0d expected 0", m_acc_bad - b_acc); else n_pass++;
    n_chk++; if (m_late - b_late !== 0) $display("FAIL t2_dct_entry: got %0d expected 0", m_late - b_late); else n_pass++;
    n_chk++; if (m_blk_len !== 161) $display("FAIL t2_block_latency: got %0d expected 161", m_blk_len); else n_pass++;
    cyc();
  endtask

  task automatic test_zero_frame();
    snap();
    bus.frame_mcus = 16'd0;
    bus.start = 1'b1;
    #1;
    n_chk++; if (bus.frame_done !== 1'b0) $display("FAIL t3_frame_done_early: got %0b expected 0", bus.frame_done); else n_pass++;
    cyc();
    bus.start = 1'b0;
    #1;
    n_chk++; if (bus.frame_done !== 1'b1) $display("FAIL t3_frame_done: got %0b expected 1", bus.frame_done); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL t3_busy: got %0b expected 0", bus.busy); else n_pass++;
    cyc();
    #1;
    n_chk++; if (bus.frame_done !== 1'b0) $display("FAIL t3_frame_done_pulse: got %0b expected 0", bus.frame_done); else n_pass++;
    n_chk++; if (m_ready - b_ready !== 0) $display("FAIL t3_pix_ready: got %0d expected 0", m_ready - b_ready); else n_pass++;
    n_chk++; if (m_block - b_block !== 0) $display("FAIL t3_block_done: got %0d expected 0", m_block - b_block); else n_pass++;
    cyc();
  endtask

  task automatic test_abort();
    bit found, got;
    int n;
    snap();
    bus.frame_mcus = 16'd1;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.pix_valid = 1'b1;
    found = 1'b0; n = 0;
    while (!found && n < 300) begin
      #1;
      if (bus.matrix_row == 8'd3 && bus.busy && !bus.zigzag_input_enable && !bus.dct_input_enable && !bus.pix_ready)
        found = 1'b1;
      else begin
        cyc(); n++;
      end
    end
    n_chk++; if (found !== 1'b1) $display("FAIL t4_reach_row3: got %0b expected 1", found); else n_pass++;
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    bus.pix_valid = 1'b0;
    #1;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL t4_busy: got %0b expected 0", bus.busy); else n_pass++;
    n_chk++; if ({bus.pix_ready, bus.dct_enable, bus.dct_input_enable, bus.zigzag_input_enable, bus.huff_start} !== 5'b0)
      $display("FAIL t4_enables: got %05b expected 00000",
               {bus.pix_ready, bus.dct_enable, bus.dct_input_enable, bus.zigzag_input_enable, bus.huff_start}); else n_pass++;
    n_chk++; if ({bus.block_done, bus.frame_done} !== 2'b00) $display("FAIL t4_done: got %02b expected 00", {bus.block_done, bus.frame_done}); else n_pass++;
    n_chk++; if (bus.mcu_count !== 16'd0) $display("FAIL t4_mcu_count: got %0d expected 0", bus.mcu_count); else n_pass++;
    n_chk++; if (bus.is_luminance !== 1'b1) $display("FAIL t4_is_lum: got %0b expected 1", bus.is_luminance); else n_pass++;
    n_chk++; if (m_block - b_block !== 0) $display("FAIL t4_no_block_done: got %0d expected 0", m_block - b_block); else n_pass++;
    cyc();
    snap();
    drive_frame(1, 1'b0, 3, 1'b0, got);
    n_chk++; if (got !== 1'b1) $display("FAIL t4_restart_timeout: got %0b expected 1", got); else n_pass++;
    n_chk++; if (m_row_bad - b_row !== 0) $display("FAIL t4_restart_rows: got %0d expected 0", m_row_bad - b_row); else n_pass++;
    n_chk++; if (m_zz - b_zz !== 24) $display("FAIL t4_restart_zz: got %0d expected 24", m_zz - b_zz); else n_pass++;
    n_chk++; if (m_block - b_block !== 3) $display("FAIL t4_restart_blocks: got %0d expected 3", m_block - b_block); else n_pass++;
    cyc();
  endtask

  task automatic test_hwait_start();
    bit got;
    snap();
    drive_frame(1, 1'b0, 0, 1'b1, got);
    #1;
    n_chk++; if (got !== 1'b1) $display("FAIL t5_timeout: got %0b expected 1", got); else n_pass++;
    n_chk++; if (m_block - b_block !== 3) $display("FAIL t5_blocks: got %0d expected 3", m_block - b_block); else n_pass++;
    n_chk++; if (bus.mcu_count !== 16'd1) $display("FAIL t5_mcu_count: got %0d expected 1", bus.mcu_count); else n_pass++;
    n_chk++; if (m_hs_to_bd !== 2) $display("FAIL t5_huff_to_done: got %0d expected 2", m_hs_to_bd); else n_pass++;
    n_chk++; if (m_blk_len !== 96) $display("FAIL t5_block_latency: got %0d expected 96", m_blk_len); else n_pass++;
    cyc();
  endtask

  task automatic test_reset_mid_load();
    bit got;
    int acc, n;
    bus.frame_mcus = 16'd1;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.pix_valid = 1'b1;
    acc = 0; n = 0;
    while (acc < 30 && n < 100) begin
      #1;
      if (bus.input_1pix_enable) acc++;
      cyc(); n++;
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.pix_valid = 1'b0;
    #1;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL t6_busy: got %0b expected 0", bus.busy); else n_pass++;
    n_chk++; if ({bus.pix_ready, bus.dct_enable, bus.dct_input_enable, bus.zigzag_input_enable, bus.huff_start, bus.block_done, bus.frame_done} !== 7'b0)
      $display("FAIL t6_outputs: got %07b expected 0000000",
               {bus.pix_ready, bus.dct_enable, bus.dct_input_enable, bus.zigzag_input_enable, bus.huff_start, bus.block_done, bus.frame_done}); else n_pass++;
    n_chk++; if (bus.is_luminance !== 1'b1) $display("FAIL t6_is_lum: got %0b expected 1", bus.is_luminance); else n_pass++;
    n_chk++; if (bus.matrix_row !== 8'd0) $display("FAIL t6_matrix_row: got %0d expected 0", bus.matrix_row); else n_pass++;
    cyc();
    snap();
    drive_frame(1, 1'b0, 3, 1'b0, got);
    n_chk++; if (got !== 1'b1) $display("FAIL t6_restart_timeout: got %0b expected 1", got); else n_pass++;
    n_chk++; if (m_accept - b_accept !== 192) $display("FAIL t6_accepts: got %0d expected 192", m_accept - b_accept); else n_pass++;
    n_chk++; if (m_acc_bad - b_acc !== 0) $display("FAIL t6_full_load: got %0d expected 0", m_acc_bad - b_acc); else n_pass++;
    n_chk++; if (m_blk_len !== 98) $display("FAIL t6_block_latency: got %0d expected 98", m_blk_len); else n_pass++;
    cyc();
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.frame_mcus = 16'd0;
    bus.pix_valid  = 1'b0;
    bus.huff_done  = 1'b0;
    test_reset();
    test_single_frame();
    test_pixel_stall();
    test_zero_frame();
    test_abort();
    test_hwait_start();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jpeg_block_sequencer.md
Name: jpeg_block_sequencer

Overview:
- Sequences one 8x8 block at a time through the encoder datapath: 1-pixel input buffer load, DCT_2D, DCT result capture, row-wise Quantize into the zigzag buffer, then the Huffman controller.
- Generates the enables and `matrix_row` that the top level currently takes as primary inputs.
- Tracks component order (Y, Cb, Cr per MCU, 4:4:4) to drive `is_luminance`, and counts MCUs per frame.

Parameters:
- `DCT_LAT`, 4: cycles `dct_enable` is held high before the result is captured (≥1).
- `QUANT_LAT`, 2: cycles `matrix_row` is held stable before `zigzag_input_enable` for that row (≥1).
- `MCU_W`, 16: width of the MCU counter.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; begins a frame when idle.
- `abort`  in  1  synchronous; returns to IDLE, no done pulses.
- `frame_mcus`  in  MCU_W  MCUs in the frame; latched on accepted start.
- `pix_valid`  in  1  upstream pixel valid.
- `pix_ready`  out  1  high only in LOAD.
- `input_1pix_enable`  out  1  = pix_valid & pix_ready (combinational); buffer write strobe.
- `dct_enable`  out  1  DCT_2D run.
- `dct_input_enable`  out  1  capture DCT result into the quantize buffer.
- `matrix_row`  out  8  binary row index 0..7.
- `zigzag_input_enable`  out  1  write quantized row into the zigzag buffer.
- `is_luminance`  out  1  1 for the Y block, 0 for Cb/Cr.
- `huff_start`  out  1  1-cycle pulse to the Huffman controller.
- `huff_done`  in  1  Huffman controller finished the block.
- `block_done`  out  1  1-cycle pulse per block.
- `frame_done`  out  1  1-cycle pulse at end of frame.
- `busy`  out  1  state != IDLE.
- `mcu_count`  out  MCU_W  MCUs completed in the current frame.

Behaviour:
- Reset, next edge:
  - state = IDLE.
  - All outputs 0, except `is_luminance` = 1.
  - All counters 0.
- States: IDLE, LOAD, DCT, CAPT, QWAIT, QWRITE, HSTART, HWAIT, DONE.
- IDLE:
  - start=1 and frame_mcus != 0: latch frame_mcus, comp=0, mcu_count=0, go to LOAD.
  - start=1 and frame_mcus = 0: `frame_done` pulses the next cycle; stay in IDLE.
  - start while busy: ignored.
- LOAD:
  - pix_ready=1; each accept increments pix_cnt (6-bit).
  - On the accept with pix_cnt=63: pix_cnt wraps to 0, go to DCT.
  - Gaps in pix_valid stall with no loss.
- DCT: `dct_enable`=1 for exactly DCT_LAT cycles (wait counter), then CAPT.
- CAPT: `dct_input_enable`=1 for one cycle; row=0; go to QWAIT.
- QWAIT: `matrix_row`=row for QUANT_LAT cycles, then QWRITE.
- QWRITE:
  - `zigzag_input_enable`=1 for one cycle with `matrix_row` still = row.
  - row<7: row++, back to QWAIT.
  - row=7: go to HSTART.
- `matrix_row` holds its last value outside QWAIT/QWRITE; it resets to 0.
- HSTART: `huff_start`=1 for one cycle, then HWAIT.
  - huff_done is not sampled in HSTART.
- HWAIT: wait for huff_done=1, then DONE. No timeout.
- DONE: `block_done`=1 for one cycle, then advance:
  - comp 0→1→2.
  - comp 2 → comp 0 and mcu_count++.
  - If mcu_count reaches frame_mcus: `frame_done`=1 in the same cycle as `block_done`, go to IDLE.
  - Otherwise go to LOAD.
- `is_luminance` = (comp==0), registered; stable for the whole block.
- Block latency with continuous pixels: 64 + DCT_LAT + 1 + 8·(QUANT_LAT+1) + 1 + H + 1 cycles, where H = cycles spent in HWAIT (≥1).
- abort: acts on the next edge from any state.
  - Go to IDLE with counters cleared.
  - `block_done`/`frame_done` are not asserted.
  - `mcu_count` clears to 0.
- Priority: reset > abort > start.
- mcu_count saturates at frame_mcus; no overflow is possible.

Decomposition:
- Shared package `jpeg_pkg` holds:
  - the state enum type;
  - localparams BLOCK_PIX=64 and BLOCK_ROWS=8;
  - component codes COMP_Y=0, COMP_CB=1, COMP_CR=2.
- One sub-module, `jpeg_wait_counter`: a loadable down-counter with a `done` flag, shared by the DCT and QWAIT waits.
- Everything else stays in this module.

Test Plan (defaults DCT_LAT=4, QUANT_LAT=2):
1. Single block: frame_mcus=1, pixels back-to-back, huff_done asserted 3 cycles after huff_start.
   - input_1pix_enable high 64 consecutive cycles; dct_enable 4 cycles; one dct_input_enable.
   - matrix_row steps 0..7, each with one zigzag_input_enable 2 cycles after the row change.
   - 3 block_done pulses (Y, Cb, Cr) with is_luminance 1, 0, 0.
   - frame_done coincides with the third block_done; mcu_count=1.
2. Pixel stall: pix_valid toggles every other cycle.
   - Exactly 64 accepts over 127 cycles; DCT entered only after the 64th accept.
3. frame_mcus=0 with start → frame_done 1 cycle later; no pix_ready, no block_done.
4. Abort during QWAIT at row 3.
   - Next cycle: busy=0, all enables 0, no block_done.
   - A following start runs a full block with matrix_row starting at 0.
5. start asserted during HWAIT: ignored, frame_mcus unchanged. huff_done held high during HSTART: no transition until the HWAIT cycle.
6. Reset asserted mid-LOAD (pix_cnt=30) → next cycle all outputs 0, is_luminance=1; a restarted block requires the full 64 accepts.
